// File: rtl/bcd_seven_seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seven_seg_scan_if
//  Purpose  : BCD tens/ones pair handshake between the binary-to-BCD
//             converter (master) and the seven-segment scanner (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface bcd_seven_seg_scan_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] tens;
  logic [3:0] ones;

  modport master (
    output in_valid,
    output tens,
    output ones,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  tens,
    input  ones,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/bcd_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seven_seg_scan
//  Purpose  : Two-digit multiplexed seven-segment scanner with a shadow
//             register that is copied to the display only at frame boundaries.
//             Optional macro BCD_SCAN_LZ_BLANK_EN blanks a leading-zero tens.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_seven_seg_scan #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  bcd_seven_seg_scan_if.slave        bcd,
  output logic [6:0]                 seg,
  output logic [1:0]                 an,
  output logic                       err
);

  localparam int                 c_cnt_w   = $clog2(REFRESH_DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [6:0]         c_seg_dash  = 7'h40;
  localparam logic [6:0]         c_seg_blank = 7'h00;
  localparam logic [1:0]         c_an_ones   = 2'b01;
  localparam logic [1:0]         c_an_tens   = 2'b10;

  // State registers; {tens, ones} packed as [7:4] / [3:0].
  logic [c_cnt_w-1:0] cnt_q,     cnt_d;
  logic               digit_q,   digit_d;
  logic               pending_q, pending_d;
  logic [7:0]         shadow_q,  shadow_d;
  logic [7:0]         display_q, display_d;
  logic               err_q,     err_d;
  logic [6:0]         seg_q,     seg_d;
  logic [1:0]         an_q,      an_d;

  logic               cnt_term;
  logic               frame_boundary;
  logic               accept;
  logic               bad_digit;
  logic [3:0]         digit_val;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = c_seg_dash;
    endcase
    return s;
  endfunction

  assign cnt_term       = (cnt_q == c_cnt_max);
  assign frame_boundary = cnt_term && digit_q;
  assign accept         = bcd.in_valid && !pending_q;
  assign bad_digit      = (bcd.tens > 4'd9) || (bcd.ones > 4'd9);

  // State register process
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      digit_q   <= 1'b0;
      pending_q <= 1'b0;
      shadow_q  <= 8'h00;
      display_q <= 8'h00;
      err_q     <= 1'b0;
      seg_q     <= 7'h00;
      an_q      <= 2'b00;
    end else begin
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      err_q     <= err_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  // Next-state process
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    digit_d   = digit_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    err_d     = err_q;

    if (cnt_term) begin
      cnt_d   = '0;
      digit_d = ~digit_q;
    end

    // Transfer uses the pre-edge shadow, so a same-cycle accept waits a frame.
    if (frame_boundary && pending_q) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end

    if (accept) begin
      shadow_d  = {bcd.tens, bcd.ones};
      pending_d = 1'b1;
      if (bad_digit) begin
        err_d = 1'b1;
      end
    end
  end

  // Output process: segment/anode values registered one cycle after digit
  always_comb begin
    digit_val = digit_q ? display_q[7:4] : display_q[3:0];
    seg_d     = seg_decode(digit_val);
`ifdef BCD_SCAN_LZ_BLANK_EN
    if (digit_q && (display_q[7:4] == 4'd0)) begin
      seg_d = c_seg_blank;
    end
`endif
    an_d = digit_q ? c_an_tens : c_an_ones;
  end

  assign bcd.in_ready = ~pending_q;
  assign seg          = seg_q;
  assign an           = an_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_seven_seg_scan
//  Purpose  : Scoreboard bench for bcd_seven_seg_scan with REFRESH_DIV=4.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_seven_seg_scan;

  localparam int REFRESH_DIV = 4;
`ifdef BCD_SCAN_LZ_BLANK_EN
  localparam logic [6:0] SEG_TENS0 = 7'h00;
`else
  localparam logic [6:0] SEG_TENS0 = 7'h3F;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  bcd_seven_seg_scan_if bus ();

  bcd_seven_seg_scan #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bcd (bus),
    .seg (seg),
    .an  (an),
    .err (err)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic       mon_en   = 1'b0;
  logic [8:0] exp_q[$];

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic push_frame(input logic [6:0] ones_seg, input logic [6:0] tens_seg);
    exp_q.push_back({2'b01, ones_seg});
    exp_q.push_back({2'b10, tens_seg});
  endtask

  task automatic drive(input logic v, input logic [3:0] t, input logic [3:0] o);
    bus.in_valid = v;
    bus.tens     = t;
    bus.ones     = o;
  endtask

  // Monitor: every change of {an,seg} is one lit slot; compare and time it.
  initial begin
    logic [8:0] prev;
    logic [8:0] expv;
    int         dwell;
    bit         first;
    prev  = 9'h000;
    dwell = 0;
    first = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        dwell++;
        if ({an, seg} != prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_slot: got an=%b seg=0x%h required no further change", an, seg);
          end else begin
            expv = exp_q.pop_front();
            check("slot_an_seg", int'({an, seg}), int'(expv));
          end
          if (!first) check("slot_dwell", dwell, REFRESH_DIV);
          first = 1'b0;
          dwell = 0;
          prev  = {an, seg};
        end
      end
    end
  end

  initial begin
    drive(1'b0, 4'd0, 4'd0);
    rst = 1'b1;
    repeat (3) step();
    check("rst_seg", int'(seg), 'h00);
    check("rst_an", int'(an), 'h0);
    check("rst_err", int'(err), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);

    rst = 1'b0;
    cyc = 0;
    push_frame(7'h3F, SEG_TENS0);
    push_frame(7'h3F, SEG_TENS0);
    mon_en = 1'b1;

    // Accept 3/1 in the middle of frame 1's tens slot
    go_to(13);
    drive(1'b1, 4'd3, 4'd1);
    push_frame(7'h06, 7'h4F);
    go_to(14);
    check("ready_after_accept", int'(bus.in_ready), 0);
    drive(1'b1, 4'd2, 4'd5);
    go_to(15);
    check("ready_stall", int'(bus.in_ready), 0);
    go_to(16);
    check("ready_after_boundary", int'(bus.in_ready), 1);
    push_frame(7'h6D, 7'h5B);
    go_to(17);
    check("ready_after_second_accept", int'(bus.in_ready), 0);
    drive(1'b0, 4'd0, 4'd0);

    // Accept 1/9 on the boundary edge 32: not transferred until edge 40
    go_to(31);
    drive(1'b1, 4'd1, 4'd9);
    push_frame(7'h6D, 7'h5B);
    push_frame(7'h6F, 7'h06);
    go_to(32);
    drive(1'b0, 4'd0, 4'd0);
    check("ready_after_collision_accept", int'(bus.in_ready), 0);
    go_to(39);
    check("ready_collision_pending", int'(bus.in_ready), 0);
    go_to(40);
    check("ready_after_collision_transfer", int'(bus.in_ready), 1);
    check("err_before_invalid", int'(err), 0);

    // Non-BCD tens digit
    drive(1'b1, 4'hC, 4'd7);
    push_frame(7'h07, 7'h40);
    go_to(41);
    drive(1'b0, 4'd0, 4'd0);
    check("err_after_invalid", int'(err), 1);

    go_to(48);
    drive(1'b1, 4'd0, 4'd8);
    push_frame(7'h7F, SEG_TENS0);
    go_to(49);
    drive(1'b0, 4'd0, 4'd0);

    go_to(63);
    mon_en = 1'b0;
    check("scoreboard_drained", exp_q.size(), 0);
    check("err_sticky", int'(err), 1);

    // Leave a value pending, then reset: it must be discarded
    go_to(64);
    drive(1'b1, 4'd9, 4'd9);
    go_to(65);
    drive(1'b0, 4'd0, 4'd0);
    check("ready_pending_before_reset", int'(bus.in_ready), 0);
    go_to(66);
    rst = 1'b1;
    step();
    check("rst2_seg", int'(seg), 'h00);
    check("rst2_an", int'(an), 'h0);
    check("rst2_err", int'(err), 0);
    check("rst2_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;
    cyc = 0;
    go_to(1);
    check("rst2_first_an", int'(an), 'h1);
    check("rst2_first_seg", int'(seg), 'h3F);
    go_to(5);
    check("rst2_tens_an", int'(an), 'h2);
    check("rst2_tens_seg", int'(seg), int'(SEG_TENS0));
    go_to(9);
    check("rst2_frame1_ones_seg", int'(seg), 'h3F);
    go_to(13);
    check("rst2_frame1_tens_seg", int'(seg), int'(SEG_TENS0));
    check("rst2_ready", int'(bus.in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
